// File: rtl/core_run_scheduler.sv
// Run-level scheduler: launches the masked cores, collects their end_process, releases them, reports done.
// Optional run watchdog enabled by defining RUN_TIMEOUT_EN.
module core_run_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_CORES-1:0]   core_mask,
    input  logic [NUM_CORES-1:0]   end_process,
    output logic [2*NUM_CORES-1:0] core_status,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_CORES-1:0]   done_mask,
    output logic                   error
);

    // state    | meaning
    // IDLE     | waiting for host start
    // LAUNCH   | one cycle of 2'b01 to every masked core
    // RUN      | accumulating end_process of masked cores
    // RELEASE  | one cycle of 2'b10 to every masked core
    // DONE     | one-cycle completion pulse to host
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] CODE_START   = 2'b01;
    localparam logic [1:0] CODE_RELEASE = 2'b10;

    state_t                 r_state;
    logic [NUM_CORES-1:0]   r_mask;
    logic [NUM_CORES-1:0]   r_fin;
    logic [NUM_CORES-1:0]   r_done_mask;
    logic [2*NUM_CORES-1:0] r_status;
    logic                   r_busy;
    logic                   r_done;

    logic [NUM_CORES-1:0]   w_fin_next;
    logic                   w_all_fin;

    function automatic logic [2*NUM_CORES-1:0] f_code(input logic [NUM_CORES-1:0] mask,
                                                      input logic [1:0] code);
        logic [2*NUM_CORES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (mask[i]) v[2*i +: 2] = code;
        end
        return v;
    endfunction

    assign w_fin_next = r_fin | (end_process & r_mask);
    assign w_all_fin  = (w_fin_next == r_mask);

`ifdef RUN_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_ONES = '1;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_error;
    logic [TIMEOUT_W-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + 1'b1;
    assign error      = r_error;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_fin       <= '0;
            r_done_mask <= '0;
            r_status    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef RUN_TIMEOUT_EN
            r_cnt       <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask      <= core_mask;
                        r_fin       <= '0;
                        r_done_mask <= '0;
`ifdef RUN_TIMEOUT_EN
                        r_error     <= 1'b0;
`endif
                        if (core_mask != '0) begin
                            r_state  <= S_LAUNCH;
                            r_status <= f_code(core_mask, CODE_START);
                            r_busy   <= 1'b1;
                        end else begin
                            // empty run: report completion without touching any core
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_status <= '0;
                    r_state  <= S_RUN;
`ifdef RUN_TIMEOUT_EN
                    r_cnt    <= '0;
`endif
                end
                S_RUN: begin
                    r_fin <= w_fin_next;
                    if (w_all_fin) begin
                        r_state  <= S_RELEASE;
                        r_status <= f_code(r_mask, CODE_RELEASE);
`ifdef RUN_TIMEOUT_EN
                    end else if (w_cnt_next == CNT_ONES) begin
                        r_state  <= S_RELEASE;
                        r_status <= f_code(r_mask, CODE_RELEASE);
                        r_error  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
`endif
                    end
                end
                S_RELEASE: begin
                    r_status    <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_done_mask <= r_fin;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_status <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign core_status = r_status;
    assign busy        = r_busy;
    assign done        = r_done;
    assign done_mask   = r_done_mask;

endmodule

// File: tb/tb_core_run_scheduler.sv
// Scoreboard bench for core_run_scheduler: random runs against a run-level reference model.
module tb_core_run_scheduler;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NC-1:0] core_mask;
    logic [NC-1:0] end_process;
    logic [2*NC-1:0] core_status;
    logic          busy;
    logic          done;
    logic [NC-1:0] done_mask;
    logic          error;

    core_run_scheduler #(.NUM_CORES(NC), .TIMEOUT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .core_mask   (core_mask),
        .end_process (end_process),
        .core_status (core_status),
        .busy        (busy),
        .done        (done),
        .done_mask   (done_mask),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  st;
        logic        d;
        logic [3:0]  dm;
        logic        e;
        logic        b;
    } ev_t;

    ev_t expq[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] code_of(input logic [3:0] m, input logic [1:0] c);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) if (m[i]) v[2*i +: 2] = c;
        return v;
    endfunction

    // Monitor: every visible status code or done pulse is one scoreboard event.
    always @(negedge clk) begin
        if (rst_n && (core_status != '0 || done)) begin
            ev_t x;
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d status=%h done=%b dm=%b err=%b",
                         cyc, core_status, done, done_mask, error);
            end else begin
                x = expq.pop_front();
                if (x.cyc != cyc || x.st != core_status || x.d != done ||
                    x.dm != done_mask || x.e != error || x.b != busy) begin
                    failures++;
                    $display("FAIL event got cyc=%0d st=%h done=%b dm=%b err=%b busy=%b exp cyc=%0d st=%h done=%b dm=%b err=%b busy=%b",
                             cyc, core_status, done, done_mask, error, busy,
                             x.cyc, x.st, x.d, x.dm, x.e, x.b);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if (core_status != '0 || busy || done || done_mask != '0 || error) begin
            failures++;
            $display("FAIL %s got st=%h busy=%b done=%b dm=%b err=%b exp all zero",
                     name, core_status, busy, done, done_mask, error);
        end
    endtask

    // One run: tfix>0 makes every masked core end at that RUN cycle; rst_mid resets during RUN.
    task automatic run_one(input logic [3:0] m, input int tfix, input bit rst_mid);
        logic [3:0] sched[32];
        int         t[NC];
        int         k_end;
        int         n_cyc;
        bit         to;
        logic [3:0] fin;
        int         c0;

        for (int i = 0; i < NC; i++) begin
            t[i] = (tfix > 0) ? tfix : int'($urandom_range(1, 12));
`ifdef RUN_TIMEOUT_EN
            if (tfix == 0 && $urandom_range(0, 3) == 0) t[i] = 99;
`endif
        end
        if (rst_mid) begin
            t[0] = 99;
            t[1] = 2;
        end
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < NC; i++) begin
                if (!m[i] || k == 0) sched[k][i] = 1'($urandom);
                else if (k < t[i]) sched[k][i] = 1'b0;
                else if (k == t[i]) sched[k][i] = 1'b1;
                else sched[k][i] = 1'($urandom);
            end
        end

        fin = '0; k_end = 0; to = 1'b0;
        if (m != '0) begin
            for (int k = 1; k < 30; k++) begin
                fin = fin | (sched[k] & m);
                if (fin == m) begin k_end = k; break; end
`ifdef RUN_TIMEOUT_EN
                if (k == 15) begin k_end = k; to = 1'b1; break; end
`endif
            end
        end

        c0 = cyc;
        start = 1'b1;
        core_mask = m;
        if (m == '0) begin
            expq.push_back('{c0 + 1, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0});
            n_cyc = 1;
        end else begin
            expq.push_back('{c0 + 1, code_of(m, 2'b01), 1'b0, 4'h0, 1'b0, 1'b1});
            if (!rst_mid) begin
                expq.push_back('{c0 + 2 + k_end, code_of(m, 2'b10), 1'b0, 4'h0, to, 1'b1});
                expq.push_back('{c0 + 3 + k_end, 8'h00, 1'b1, fin, to, 1'b0});
            end
            n_cyc = rst_mid ? 4 : k_end + 3;
        end

        @(negedge clk);
        for (int j = 0; j < n_cyc; j++) begin
            end_process = sched[j];
            start = 1'($urandom);
            core_mask = 4'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        if (rst_mid) begin
            #2 rst_n = 1'b0;
            #1 check_idle_outputs("async_reset_mid_run");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_idle_outputs("after_mid_run_reset");
        end

        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        core_mask = '0;
        end_process = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");

        run_one(4'b1111, 10, 1'b0);
        run_one(4'b0101, 0, 1'b0);
        run_one(4'b0000, 0, 1'b0);
        run_one(4'b0001, 1, 1'b0);
        for (int r = 0; r < 40; r++) run_one(4'($urandom), 0, 1'b0);
        run_one(4'b0011, 0, 1'b1);
        run_one(4'b1010, 0, 1'b0);
        run_one(4'b0000, 0, 1'b0);

        repeat (5) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL events_missing got %0d pending exp 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
